// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmitter: register offsets, status bit positions,
// FSM state encodings and the status-byte packer.
package uart_tx_port_pkg;

    localparam logic [15:0] UART_REG_DATA   = 16'd0;
    localparam logic [15:0] UART_REG_STATUS = 16'd1;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    function automatic logic [7:0] status_byte(input logic ovf, input logic busy,
                                               input logic empty, input logic full);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_OVF]   = ovf;
        s[ST_BUSY]  = busy;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// CPU bus slice seen by the transmitter: address, write data/strobe and registered read data.
// The master drives the bus; the peripheral returns data_out (8'h00 when not selected).
interface uart_tx_port_if;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        write_enable;
    logic [7:0]  data_out;

    modport master (output addr, output data_in, output write_enable, input data_out);
    modport slave  (input addr, input data_in, input write_enable, output data_out);
endinterface

// File: rtl/uart_tx_port_sync_fifo.sv
// Generic single-clock FIFO, 2**AW entries; pushes when full and pops when empty are ignored.
// Read data is the head entry, valid combinationally whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits, so wrap modulo depth falls out of the width.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter with an 8-entry write FIFO; write-to-start-bit is 2 cycles.
// A push into a full FIFO is dropped and latches the sticky overflow flag.
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hE010,
    parameter int          CLK_DIV   = 328,
    parameter int          FIFO_AW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_port_if.slave bus,
    output logic          tx
);
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    logic             sel_data;
    logic             sel_status;
    logic             push;
    logic             pop;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             overflow;

    logic [1:0]       state;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             baud_tick;

    assign sel_data   = (bus.addr == BASE_ADDR + UART_REG_DATA);
    assign sel_status = (bus.addr == BASE_ADDR + UART_REG_STATUS);
    assign push       = bus.write_enable && sel_data;
    assign baud_tick  = (baud_cnt == 16'd0);
    // A frame may start from IDLE or straight out of the last stop-bit cycle.
    assign pop        = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && baud_tick));

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (bus.data_in),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end else if (bus.write_enable && sel_status && bus.data_in[ST_OVF]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_out <= 8'h00;
        end else if (sel_status) begin
            bus.data_out <= status_byte(overflow, state != S_IDLE,
                                        fifo_count == '0, fifo_count[FIFO_AW]);
        end else begin
            bus.data_out <= 8'h00;
        end
    end

    // tx is loaded with the level of the state being entered, so it changes on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= fifo_rd_data;
                        baud_cnt <= DIV_M1;
                        state    <= S_START;
                        tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        baud_cnt <= DIV_M1;
                        bit_idx  <= 3'd0;
                        state    <= S_DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= DIV_M1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (pop) begin
                            shift    <= fifo_rd_data;
                            baud_cnt <= DIV_M1;
                            state    <= S_START;
                            tx       <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
